// File: rtl/systolic_tile_ctrl_if.sv
// Handshake, FIFO-control and result-drain signals between systolic_tile_ctrl and its surroundings.
// The master modport is the controller's view; slave is the stream/FIFO/array side.
interface systolic_tile_ctrl_if #(
   parameter int SIZE  = 16,
   parameter int DEPTH = 16,
   parameter int KW    = $clog2(DEPTH + 1),
   parameter int RW    = $clog2(SIZE)
);
   logic [KW-1:0]   cfg_k;
   logic            x_send_val;
   logic            x_send_rdy;
   logic            w_send_val;
   logic            w_send_rdy;
   logic [SIZE-1:0] x_fifo_wen;
   logic [SIZE-1:0] w_fifo_wen;
   logic [SIZE-1:0] x_fifo_ren;
   logic [SIZE-1:0] w_fifo_ren;
   logic [SIZE-1:0] x_fifo_empty;
   logic [SIZE-1:0] w_fifo_empty;
   logic            mac_en;
   logic            mac_clr;
   logic [RW-1:0]   out_row;
   logic            out_val;
   logic            out_rdy;
   logic            tile_done;
   logic            err;

   modport master (
      input  cfg_k, x_send_val, w_send_val, x_fifo_empty, w_fifo_empty, out_rdy,
      output x_send_rdy, w_send_rdy, x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren,
             mac_en, mac_clr, out_row, out_val, tile_done, err
   );

   modport slave (
      output cfg_k, x_send_val, w_send_val, x_fifo_empty, w_fifo_empty, out_rdy,
      input  x_send_rdy, w_send_rdy, x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren,
             mac_en, mac_clr, out_row, out_val, tile_done, err
   );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// Tile controller for a SIZE x SIZE systolic MAC array: load K beats per stream,
// run a diagonal read wavefront for K + 2*(SIZE-1) cycles, then drain SIZE result rows.
module systolic_tile_ctrl #(
   parameter int SIZE  = 16,
   parameter int DEPTH = 16,
   parameter int KW    = $clog2(DEPTH + 1)
) (
   input logic               clk,
   input logic               rst,
   systolic_tile_ctrl_if.master bus
);
   localparam int CW = $clog2(DEPTH + 2 * SIZE);
   localparam int RW = $clog2(SIZE);

   typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

   state_t          state, state_nxt;
   logic [KW-1:0]   k_reg, k_cfg, x_cnt, w_cnt;
   logic [CW-1:0]   c, c_last;
   logic [RW-1:0]   r;
   logic            err_q;
   logic            x_rdy, w_rdy, x_acc, w_acc;
   logic            mac_last, fifo_left, row_acc, done;
   logic            mac_en, mac_clr, out_val;
   logic [SIZE-1:0] ren;

   assign k_cfg = (bus.cfg_k == '0 || bus.cfg_k > KW'(DEPTH)) ? KW'(DEPTH) : bus.cfg_k;
   assign c_last = CW'(k_reg) + CW'(2 * SIZE - 3);

   // Ready depends only on state and counters, never on val.
   assign x_rdy = (state == LOAD) && (x_cnt < k_reg);
   assign w_rdy = (state == LOAD) && (w_cnt < k_reg);
   assign x_acc = x_rdy && bus.x_send_val;
   assign w_acc = w_rdy && bus.w_send_val;

   assign mac_last  = (state == MAC) && (c == c_last);
   assign fifo_left = !((&bus.x_fifo_empty) && (&bus.w_fifo_empty));
   assign row_acc   = (state == OUT) && bus.out_rdy;

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mac_en    = 1'b0;
      mac_clr   = 1'b0;
      out_val   = 1'b0;
      done      = 1'b0;
      ren       = '0;
      case (state)
         LOAD: begin
            if (x_cnt == k_reg && w_cnt == k_reg) state_nxt = MAC;
         end
         MAC: begin
            mac_en  = 1'b1;
            mac_clr = (c == '0);
            for (int unsigned i = 0; i < SIZE; i++)
               ren[i] = (c >= CW'(i)) && (c < CW'(i) + CW'(k_reg));
            if (mac_last) state_nxt = OUT;
         end
         OUT: begin
            out_val = 1'b1;
            if (bus.out_rdy && r == RW'(SIZE - 1)) begin
               done      = 1'b1;
               state_nxt = LOAD;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   // k_reg is (re)latched on every entry into LOAD, including the reset edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_reg <= k_cfg;
         x_cnt <= '0;
         w_cnt <= '0;
         c     <= '0;
         r     <= '0;
         err_q <= 1'b0;
      end else begin
         if (x_acc) x_cnt <= x_cnt + KW'(1);
         if (w_acc) w_cnt <= w_cnt + KW'(1);
         if (state == MAC) c <= mac_last ? '0 : c + CW'(1);
         if (mac_last && fifo_left) err_q <= 1'b1;
         if (row_acc) r <= done ? '0 : r + RW'(1);
         if (done) begin
            k_reg <= k_cfg;
            x_cnt <= '0;
            w_cnt <= '0;
         end
      end
   end

   assign bus.x_send_rdy = x_rdy;
   assign bus.w_send_rdy = w_rdy;
   assign bus.x_fifo_wen = {SIZE{x_acc}};
   assign bus.w_fifo_wen = {SIZE{w_acc}};
   assign bus.x_fifo_ren = ren;
   assign bus.w_fifo_ren = ren;
   assign bus.mac_en     = mac_en;
   assign bus.mac_clr    = mac_clr;
   assign bus.out_val    = out_val;
   assign bus.out_row    = r;
   assign bus.tile_done  = done;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed bench for systolic_tile_ctrl with SIZE=4, DEPTH=8 and an occupancy model of the lane FIFOs.
module tb_systolic_tile_ctrl;
   localparam int SIZE  = 4;
   localparam int DEPTH = 8;
   localparam int KW    = $clog2(DEPTH + 1);
   localparam int RW    = $clog2(SIZE);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_tile_ctrl_if #(.SIZE(SIZE), .DEPTH(DEPTH), .KW(KW), .RW(RW)) bus ();

   systolic_tile_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .KW(KW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   ncmp  = 0;
   int   nfail = 0;
   int   xocc[SIZE];
   int   wocc[SIZE];
   logic stuck1;

   // Lane occupancy: wen pushes, ren pops; stuck1 pins lane 1 non-empty.
   always @(posedge clk) begin
      for (int i = 0; i < SIZE; i++) begin
         if (rst) begin
            xocc[i] <= 0;
            wocc[i] <= 0;
         end else begin
            xocc[i] <= xocc[i] + int'(bus.x_fifo_wen[i]) - int'(bus.x_fifo_ren[i]);
            wocc[i] <= wocc[i] + int'(bus.w_fifo_wen[i]) - int'(bus.w_fifo_ren[i]);
         end
      end
   end

   always_comb begin
      bus.x_fifo_empty = '0;
      bus.w_fifo_empty = '0;
      for (int i = 0; i < SIZE; i++) begin
         bus.x_fifo_empty[i] = (xocc[i] == 0) && !(stuck1 && i == 1);
         bus.w_fifo_empty[i] = (wocc[i] == 0);
      end
   end

   logic [SIZE-1:0] ren_k3 [9] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SIZE-1:0] ren_exp(input int c, input int k);
      logic [SIZE-1:0] e = '0;
      for (int i = 0; i < SIZE; i++)
         if (c - i >= 0 && c - i < k) e[i] = 1'b1;
      return e;
   endfunction

   task automatic load_both(input int k);
      bus.x_send_val = 1'b1;
      bus.w_send_val = 1'b1;
      for (int i = 0; i < k; i++) begin
         #1;
         chk("load_x_rdy", 32'(bus.x_send_rdy), 1);
         chk("load_w_rdy", 32'(bus.w_send_rdy), 1);
         chk("load_x_wen", 32'(bus.x_fifo_wen), 'hF);
         chk("load_w_wen", 32'(bus.w_fifo_wen), 'hF);
         cyc();
      end
      #1;
      chk("full_x_rdy", 32'(bus.x_send_rdy), 0);
      chk("full_w_rdy", 32'(bus.w_send_rdy), 0);
      chk("full_x_wen", 32'(bus.x_fifo_wen), 0);
      chk("full_w_wen", 32'(bus.w_fifo_wen), 0);
      chk("full_mac_en", 32'(bus.mac_en), 0);
      bus.x_send_val = 1'b0;
      bus.w_send_val = 1'b0;
      cyc();
   endtask

   task automatic mac_phase(input int k);
      logic [SIZE-1:0] e;
      for (int c = 0; c < k + 2 * SIZE - 2; c++) begin
         #1;
         if (k == 3) e = ren_k3[c];
         else        e = ren_exp(c, k);
         chk("mac_en", 32'(bus.mac_en), 1);
         chk("mac_clr", 32'(bus.mac_clr), 32'(c == 0));
         chk("x_ren", 32'(bus.x_fifo_ren), 32'(e));
         chk("w_ren", 32'(bus.w_fifo_ren), 32'(e));
         chk("mac_x_rdy", 32'(bus.x_send_rdy), 0);
         chk("mac_out_val", 32'(bus.out_val), 0);
         cyc();
      end
      #1;
      chk("mac_end_en", 32'(bus.mac_en), 0);
      chk("out_entry_val", 32'(bus.out_val), 1);
   endtask

   task automatic drain(input int next_k);
      bus.cfg_k = KW'(next_k);
      for (int r = 0; r < SIZE; r++) begin
         bus.out_rdy = 1'b1;
         #1;
         chk("drain_val", 32'(bus.out_val), 1);
         chk("drain_row", 32'(bus.out_row), r);
         chk("drain_done", 32'(bus.tile_done), 32'(r == SIZE - 1));
         chk("drain_mac_en", 32'(bus.mac_en), 0);
         cyc();
      end
      #1;
      chk("post_done", 32'(bus.tile_done), 0);
      chk("post_out_val", 32'(bus.out_val), 0);
      chk("post_x_rdy", 32'(bus.x_send_rdy), 1);
      bus.out_rdy = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      stuck1         = 1'b0;
      bus.cfg_k      = KW'(3);
      bus.x_send_val = 1'b0;
      bus.w_send_val = 1'b0;
      bus.out_rdy    = 1'b0;
      cyc();
      cyc();
      #1;
      chk("rst_x_rdy", 32'(bus.x_send_rdy), 1);
      chk("rst_w_rdy", 32'(bus.w_send_rdy), 1);
      chk("rst_mac_en", 32'(bus.mac_en), 0);
      chk("rst_out_val", 32'(bus.out_val), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_done", 32'(bus.tile_done), 0);
      chk("rst_ren", 32'(bus.x_fifo_ren), 0);
      rst = 1'b0;
      cyc();

      // Tile 1: k=3, continuous streams
      load_both(3);
      mac_phase(3);
      chk("t1_err", 32'(bus.err), 0);
      drain(3);

      // Tile 2: x arrives 3 cycles ahead of w
      bus.x_send_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("skew_x_wen", 32'(bus.x_fifo_wen), 'hF);
         chk("skew_w_wen", 32'(bus.w_fifo_wen), 0);
         chk("skew_w_rdy", 32'(bus.w_send_rdy), 1);
         cyc();
      end
      bus.w_send_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("skew_x_rdy_off", 32'(bus.x_send_rdy), 0);
         chk("skew_x_wen_off", 32'(bus.x_fifo_wen), 0);
         chk("skew_w_wen_on", 32'(bus.w_fifo_wen), 'hF);
         chk("skew_no_mac", 32'(bus.mac_en), 0);
         cyc();
      end
      #1;
      chk("skew_w_rdy_off", 32'(bus.w_send_rdy), 0);
      chk("skew_gap_mac", 32'(bus.mac_en), 0);
      bus.x_send_val = 1'b0;
      bus.w_send_val = 1'b0;
      cyc();
      mac_phase(3);

      // Drain with a 5-cycle stall on row 2; next tile uses k=8
      bus.cfg_k = KW'(8);
      for (int r = 0; r < 2; r++) begin
         bus.out_rdy = 1'b1;
         #1;
         chk("stall_pre_row", 32'(bus.out_row), r);
         cyc();
      end
      bus.out_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_val", 32'(bus.out_val), 1);
         chk("stall_row", 32'(bus.out_row), 2);
         chk("stall_done", 32'(bus.tile_done), 0);
         cyc();
      end
      bus.out_rdy = 1'b1;
      #1;
      chk("stall_rel_row", 32'(bus.out_row), 2);
      chk("stall_rel_done", 32'(bus.tile_done), 0);
      cyc();
      #1;
      chk("stall_last_row", 32'(bus.out_row), 3);
      chk("stall_last_done", 32'(bus.tile_done), 1);
      cyc();
      #1;
      chk("stall_post_rdy", 32'(bus.x_send_rdy), 1);
      chk("stall_post_val", 32'(bus.out_val), 0);
      bus.out_rdy = 1'b0;

      // Tile 3: k=8; tile 4: cfg_k=0 maps to 8, with lane 1 stuck non-empty
      load_both(8);
      mac_phase(8);
      drain(0);
      load_both(8);
      stuck1 = 1'b1;
      mac_phase(8);
      chk("stuck_err", 32'(bus.err), 1);
      drain(3);
      stuck1 = 1'b0;
      chk("stuck_err_load", 32'(bus.err), 1);

      // Tile 5: err stays sticky across a clean tile
      load_both(3);
      mac_phase(3);
      drain(3);
      chk("sticky_err", 32'(bus.err), 1);

      // Tile 6: reset at MAC c=4
      load_both(3);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("pre_rst_mac_en", 32'(bus.mac_en), 1);
         cyc();
      end
      #1;
      chk("pre_rst_ren", 32'(bus.x_fifo_ren), 'hC);
      rst = 1'b1;
      cyc();
      #1;
      chk("mrst_mac_en", 32'(bus.mac_en), 0);
      chk("mrst_mac_clr", 32'(bus.mac_clr), 0);
      chk("mrst_x_ren", 32'(bus.x_fifo_ren), 0);
      chk("mrst_w_ren", 32'(bus.w_fifo_ren), 0);
      chk("mrst_err", 32'(bus.err), 0);
      chk("mrst_out_val", 32'(bus.out_val), 0);
      chk("mrst_row", 32'(bus.out_row), 0);
      chk("mrst_x_rdy", 32'(bus.x_send_rdy), 1);
      rst = 1'b0;
      cyc();

      // Tile 7: fresh counters, exactly 3 beats, clean err
      load_both(3);
      mac_phase(3);
      drain(3);
      chk("final_err", 32'(bus.err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
